// File: rtl/morse_sequencer.sv
// Morse letter sequencer: a 4-deep FIFO of 3-bit letter codes (A..H) feeding
// a fixed-rate serializer that emits each letter's 12-slot on/off pattern,
// followed by GAP_SLOTS low slots between letters.
module morse_sequencer #(
  parameter int TICK_DIV  = 250,
  parameter int GAP_SLOTS = 3
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic [2:0] LetterIn,
  input  logic       LetterValid,
  output logic       LetterReady,
  input  logic       Abort,
  output logic       DotDashOut,
  output logic       Busy,
  output logic [2:0] Count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(TICK_DIV - 1);
  localparam logic [2:0] GAP_RELOAD = 3'(GAP_SLOTS - 1);

  // Letter code to on/off slot pattern, first slot in bit 11.
  function automatic logic [11:0] letter_pattern(input logic [2:0] code);
    logic [11:0] pat;
    case (code)
      3'd0:    pat = 12'b1011_1000_0000;  // A
      3'd1:    pat = 12'b1110_1010_1000;  // B
      3'd2:    pat = 12'b1110_1011_1010;  // C
      3'd3:    pat = 12'b1110_1010_0000;  // D
      3'd4:    pat = 12'b1000_0000_0000;  // E
      3'd5:    pat = 12'b1010_1110_1000;  // F
      3'd6:    pat = 12'b1110_1110_1000;  // G
      3'd7:    pat = 12'b1010_1010_0000;  // H
      default: pat = 12'b0000_0000_0000;
    endcase
    return pat;
  endfunction

  state_t      state_q;
  logic        dot_q;
  logic [11:0] shreg_q;
  logic [3:0]  bit_cnt_q;
  logic [2:0]  gap_cnt_q;
  logic [7:0]  div_q;

  logic [2:0]  mem_q [4];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  count_q;
  logic [2:0]  count_d;

  logic        push_s;
  logic        pop_s;
  logic        tick_s;
  logic [11:0] head_pat_s;

  // FIFO handshake, occupancy next-state, slot tick and head pattern lookup.
  always_comb begin
    push_s     = 1'b0;
    pop_s      = 1'b0;
    count_d    = count_q;
    tick_s     = (state_q != IDLE) && (div_q == 8'd0);
    head_pat_s = letter_pattern(mem_q[rd_ptr_q]);
    if (Abort) begin
      // Flush wins over everything, including a simultaneous push.
      push_s  = 1'b0;
      pop_s   = 1'b0;
      count_d = 3'd0;
    end else begin
      pop_s  = (state_q == LOAD) && (count_q != 3'd0);
      // A full FIFO still accepts a push when the head leaves on the same edge.
      push_s = LetterValid && ((count_q < 3'd4) || pop_s);
      if (push_s && !pop_s) begin
        count_d = count_q + 3'd1;
      end else if (pop_s && !push_s) begin
        count_d = count_q - 3'd1;
      end else begin
        count_d = count_q;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 3'd0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      count_q <= count_d;
      if (Abort) begin
        wr_ptr_q <= 2'd0;
        rd_ptr_q <= 2'd0;
      end else begin
        if (push_s) begin
          mem_q[wr_ptr_q] <= LetterIn;
          wr_ptr_q        <= wr_ptr_q + 2'd1;
        end
        if (pop_s) begin
          rd_ptr_q <= rd_ptr_q + 2'd1;
        end
      end
    end
  end

  // Sequencer FSM with slot divider, pattern shifter and registered output.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      dot_q     <= 1'b0;
      shreg_q   <= 12'd0;
      bit_cnt_q <= 4'd0;
      gap_cnt_q <= 3'd0;
      div_q     <= DIV_RELOAD;
    end else if (Abort) begin
      state_q   <= IDLE;
      dot_q     <= 1'b0;
      shreg_q   <= 12'd0;
      bit_cnt_q <= 4'd0;
      gap_cnt_q <= 3'd0;
      div_q     <= DIV_RELOAD;
    end else begin
      // Divider idles at its reload value and restarts at every slot boundary.
      if ((state_q == IDLE) || (state_q == LOAD) || tick_s) begin
        div_q <= DIV_RELOAD;
      end else begin
        div_q <= div_q - 8'd1;
      end
      case (state_q)
        IDLE: begin
          dot_q <= 1'b0;
          if (count_q != 3'd0) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // First slot goes out on the same edge the head is popped.
          dot_q     <= head_pat_s[11];
          shreg_q   <= {head_pat_s[10:0], 1'b0};
          bit_cnt_q <= 4'd11;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (tick_s) begin
            if (bit_cnt_q != 4'd0) begin
              dot_q     <= shreg_q[11];
              shreg_q   <= {shreg_q[10:0], 1'b0};
              bit_cnt_q <= bit_cnt_q - 4'd1;
            end else begin
              dot_q     <= 1'b0;
              gap_cnt_q <= GAP_RELOAD;
              state_q   <= GAP;
            end
          end
        end
        GAP: begin
          dot_q <= 1'b0;
          if (tick_s) begin
            if (gap_cnt_q != 3'd0) begin
              gap_cnt_q <= gap_cnt_q - 3'd1;
            end else if (count_q != 3'd0) begin
              state_q <= LOAD;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          dot_q   <= 1'b0;
        end
      endcase
    end
  end

  assign DotDashOut  = dot_q;
  assign Busy        = (state_q != IDLE);
  assign Count       = count_q;
  assign LetterReady = (count_q < 3'd4);

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with TICK_DIV=4, GAP_SLOTS=3.
module tb_morse_sequencer;

  localparam int TD    = 4;
  localparam int GS    = 3;
  localparam int SLOTS = (12 + GS) * TD;  // cycles from one LOAD to the next

  logic       ClockIn = 1'b0;
  logic       Resetn;
  logic [2:0] LetterIn;
  logic       LetterValid;
  logic       LetterReady;
  logic       Abort;
  logic       DotDashOut;
  logic       Busy;
  logic [2:0] Count;

  int checks = 0;
  int errors = 0;

  logic [11:0] pats [8];

  typedef struct {
    logic       valid;
    logic [2:0] code;
    logic       abort;
    logic       exp_ready;
    logic [2:0] exp_count;
    logic       exp_busy;
    logic       exp_dot;
  } vec_t;

  vec_t vecs [7];

  morse_sequencer #(.TICK_DIV(TD), .GAP_SLOTS(GS)) dut (
    .ClockIn    (ClockIn),
    .Resetn     (Resetn),
    .LetterIn   (LetterIn),
    .LetterValid(LetterValid),
    .LetterReady(LetterReady),
    .Abort      (Abort),
    .DotDashOut (DotDashOut),
    .Busy       (Busy),
    .Count      (Count)
  );

  always #5 ClockIn = ~ClockIn;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ClockIn);
    #1;
  endtask

  task automatic push(input logic [2:0] code);
    LetterValid = 1'b1;
    LetterIn    = code;
    step();
    LetterValid = 1'b0;
  endtask

  // Called at sample k=first_k after a LOAD edge (k=0 is the LOAD edge);
  // returns at k=SLOTS, the edge that decides the next LOAD or IDLE.
  task automatic send_check(input int code, input int first_k, input int exp_cnt);
    logic [11:0] p;
    logic        e;
    p = pats[code];
    chk($sformatf("count_at_letter%0d", code), {5'd0, Count}, 8'(exp_cnt));
    for (int k = first_k; k < SLOTS; k++) begin
      e = (k < 12 * TD) ? p[11 - k / TD] : 1'b0;
      chk($sformatf("dot_letter%0d_k%0d", code, k), {7'd0, DotDashOut}, {7'd0, e});
      step();
    end
    chk($sformatf("dot_gap_end%0d", code), {7'd0, DotDashOut}, 8'd0);
  endtask

  initial begin
    int seq_a [4];
    int seq_b [4];
    int bad;

    Resetn      = 1'b0;
    LetterValid = 1'b0;
    LetterIn    = 3'd0;
    Abort       = 1'b0;

    pats[0] = 12'b1011_1000_0000;
    pats[1] = 12'b1110_1010_1000;
    pats[2] = 12'b1110_1011_1010;
    pats[3] = 12'b1110_1010_0000;
    pats[4] = 12'b1000_0000_0000;
    pats[5] = 12'b1010_1110_1000;
    pats[6] = 12'b1110_1110_1000;
    pats[7] = 12'b1010_1010_0000;

    // Five pushes on consecutive cycles from idle, then a sixth while full.
    //            valid code  abort ready count busy dot
    vecs[0] = '{1'b1, 3'd1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd2, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 3'd3, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 3'd4, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 3'd5, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 3'd6, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};

    seq_a = '{2, 3, 4, 5};
    seq_b = '{3, 0, 1, 6};

    // Reset state
    step();
    chk("rst_busy",  {7'd0, Busy},        8'd0);
    chk("rst_ready", {7'd0, LetterReady}, 8'd1);
    chk("rst_count", {5'd0, Count},       8'd0);
    chk("rst_dot",   {7'd0, DotDashOut},  8'd0);
    step();
    @(negedge ClockIn);
    Resetn = 1'b1;

    // Table-driven FIFO fill
    for (int i = 0; i < 7; i++) begin
      LetterValid = vecs[i].valid;
      LetterIn    = vecs[i].code;
      Abort       = vecs[i].abort;
      step();
      chk($sformatf("ready_v%0d", i), {7'd0, LetterReady}, {7'd0, vecs[i].exp_ready});
      chk($sformatf("count_v%0d", i), {5'd0, Count},       {5'd0, vecs[i].exp_count});
      chk($sformatf("busy_v%0d",  i), {7'd0, Busy},        {7'd0, vecs[i].exp_busy});
      chk($sformatf("dot_v%0d",   i), {7'd0, DotDashOut},  {7'd0, vecs[i].exp_dot});
    end
    LetterValid = 1'b0;

    // B is at slot sample k=4 now; follow the rest in push order, G dropped.
    step();
    send_check(1, 5, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("busy_at_load_a%0d", i), {7'd0, Busy}, 8'd1);
      step();
      send_check(seq_a[i], 0, 3 - i);
    end
    chk("idle_busy_a",  {7'd0, Busy},        8'd0);
    chk("idle_count_a", {5'd0, Count},       8'd0);
    chk("idle_ready_a", {7'd0, LetterReady}, 8'd1);

    // Push into a full FIFO on the same edge as the LOAD pop.
    push(3'd4);
    push(3'd7);
    push(3'd3);
    push(3'd0);
    push(3'd1);
    chk("full_ready", {7'd0, LetterReady}, 8'd0);
    send_check(4, 2, 4);
    chk("full_count_before_pop", {5'd0, Count},       8'd4);
    chk("full_ready_before_pop", {7'd0, LetterReady}, 8'd0);
    chk("full_busy_before_pop",  {7'd0, Busy},        8'd1);
    LetterValid = 1'b1;
    LetterIn    = 3'd6;
    step();
    LetterValid = 1'b0;
    chk("push_pop_full_count", {5'd0, Count}, 8'd4);
    send_check(7, 0, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("busy_at_load_b%0d", i), {7'd0, Busy}, 8'd1);
      step();
      send_check(seq_b[i], 0, 3 - i);
    end
    chk("idle_busy_b",  {7'd0, Busy},  8'd0);
    chk("idle_count_b", {5'd0, Count}, 8'd0);

    // Abort during the fifth slot of C with two letters queued.
    push(3'd2);
    push(3'd0);
    push(3'd1);
    chk("abort_setup_count", {5'd0, Count}, 8'd2);
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("abort_c_k%0d", k), {7'd0, DotDashOut}, {7'd0, pats[2][11 - k / TD]});
      step();
    end
    chk("abort_c_k17", {7'd0, DotDashOut}, 8'd1);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("abort_dot",   {7'd0, DotDashOut},  8'd0);
    chk("abort_count", {5'd0, Count},       8'd0);
    chk("abort_busy",  {7'd0, Busy},        8'd0);
    chk("abort_ready", {7'd0, LetterReady}, 8'd1);
    bad = 0;
    repeat (200) begin
      step();
      if (DotDashOut !== 1'b0 || Busy !== 1'b0 || Count !== 3'd0) bad++;
    end
    chk("quiet_after_abort", 8'(bad), 8'd0);

    // Abort together with a push while idle.
    LetterValid = 1'b1;
    LetterIn    = 3'd3;
    Abort       = 1'b1;
    step();
    LetterValid = 1'b0;
    Abort       = 1'b0;
    chk("abort_push_count", {5'd0, Count}, 8'd0);
    chk("abort_push_busy",  {7'd0, Busy},  8'd0);
    bad = 0;
    repeat (10) begin
      step();
      if (Busy !== 1'b0 || Count !== 3'd0) bad++;
    end
    chk("no_load_after_abort_push", 8'(bad), 8'd0);

    // Asynchronous reset pulse in the middle of a gap with D queued.
    push(3'd4);
    push(3'd3);
    step();
    chk("rstgap_count", {5'd0, Count}, 8'd1);
    repeat (52) step();
    chk("rstgap_busy_pre", {7'd0, Busy},       8'd1);
    chk("rstgap_dot_pre",  {7'd0, DotDashOut}, 8'd0);
    #2;
    Resetn = 1'b0;
    #1;
    chk("rstgap_busy",  {7'd0, Busy},        8'd0);
    chk("rstgap_ready", {7'd0, LetterReady}, 8'd1);
    chk("rstgap_count0", {5'd0, Count},      8'd0);
    chk("rstgap_dot",   {7'd0, DotDashOut},  8'd0);
    #1;
    Resetn      = 1'b1;
    LetterValid = 1'b1;
    LetterIn    = 3'd7;
    step();
    LetterValid = 1'b0;
    chk("post_rst_push_count", {5'd0, Count}, 8'd1);
    chk("post_rst_push_busy",  {7'd0, Busy},  8'd0);
    step();
    chk("post_rst_load_busy",  {7'd0, Busy},       8'd1);
    chk("post_rst_load_count", {5'd0, Count},      8'd1);
    chk("post_rst_load_dot",   {7'd0, DotDashOut}, 8'd0);
    step();
    send_check(7, 0, 0);
    chk("post_rst_idle_busy", {7'd0, Busy}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
